p_accumulator: RTL and testbench
================================

Name: p_accumulator

Overview:
Downstream stage of p_multiplier. It sums a fixed-length vector of unsigned products into one dot-product result.
- Each `start` opens a new accumulation.
- The block accepts exactly VEC_LEN qualified products.
- It presents the sum with valid/ack handshake semantics until the consumer takes it.
- `in_ready` is fed back to gate the multiplier `enable`.

Parameters:
- WIDTH, 8, multiplier operand width; product width is 2*WIDTH.
- VEC_LEN, 16, products per accumulation (>=1).
- ACC_WIDTH, 2*WIDTH+$clog2(VEC_LEN), accumulator/result width (default 20).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin new accumulation; honoured in IDLE, or in HOLD when sum_ack is high the same cycle.
- prod  in  2*WIDTH  unsigned product from p_multiplier `res`.
- prod_valid  in  1  prod is a new product this cycle (registered multiplier enable AND multiplier ready).
- in_ready  out  1  block accepts products; high only in ACCUM.
- sum  out  ACC_WIDTH  accumulated result.
- sum_valid  out  1  sum is valid and held stable.
- sum_ack  in  1  consumer takes sum.
- busy  out  1  state != IDLE.
- drop_err  out  1  sticky: a product arrived while in_ready was low.
- ovf  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (synchronous, dominates all inputs): state=IDLE, acc=0, cnt=0, sum=0, sum_valid=0, in_ready=0, busy=0, drop_err=0, ovf=0. Reset mid-ACCUM or mid-HOLD discards partial and pending results.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 -> ACCUM, acc<=0, cnt<=0, ovf<=0.
  - Otherwise stay.
- ACCUM:
  - in_ready=1.
  - On prod_valid: acc <= acc + zero-extended prod; cnt <= cnt+1.
  - On prod_valid when cnt==VEC_LEN-1: sum <= acc+prod, sum_valid<=1, -> HOLD.
  - start is ignored in ACCUM. Cycles with prod_valid=0 are bubbles: no change, and prod is ignored.
- HOLD:
  - sum_valid=1 and sum stable; in_ready=0.
  - sum_ack=1 and start=0 -> IDLE, sum_valid<=0.
  - sum_ack=1 and start=1 -> ACCUM directly (acc, cnt, ovf cleared; sum_valid<=0).
  - start without sum_ack is ignored.
- Latency: sum_valid rises on the clock edge that accepts the VEC_LEN-th product, i.e. it is visible the cycle after that product is presented.
- VEC_LEN=1: the first accepted product completes the accumulation.
- cnt width: max(1, $clog2(VEC_LEN)).
- drop_err: set when prod_valid=1 and in_ready=0; cleared only by reset.
- Arithmetic: unsigned. At default ACC_WIDTH no overflow is possible.
- Without the optional feature, a narrower ACC_WIDTH wraps modulo 2^ACC_WIDTH and ovf is tied to 0.
- sum is 0 after reset and keeps its last completed value after ack.

Optional Feature:
Macro P_ACCUMULATOR_SAT_EN.
- Defined: each add is computed one bit wider. If the carry-out is set, acc clamps to all ones and ovf is set; both stay so until the next start or reset, and further adds keep acc saturated.
- Undefined: adds wrap modulo 2^ACC_WIDTH; ovf is constant 0.

Decomposition:
- Package p_accum_pkg:
  - state enum {IDLE, ACCUM, HOLD};
  - function acc_width(WIDTH, VEC_LEN) returning 2*WIDTH+$clog2(VEC_LEN);
  - ST_* encoding constants.
- Single module; no sub-module warranted. The FSM, counter and adder are small and share state.

Test Plan:
- WIDTH=8, VEC_LEN=4: reset, start, products 1,2,3,4 on consecutive valid cycles -> sum_valid rises on the edge accepting 4, sum=10, held for 5 cycles without ack; ack -> IDLE, sum_valid=0.
- Four products of 65025 (255*255) -> sum=260100, ovf=0.
- Same 1,2,3,4 with bubbles between, and prod=999 while prod_valid=0 -> sum=10, cnt unaffected by bubbles.
- Back-to-back: in HOLD assert sum_ack and start together, then feed 5,5,5,5 -> second sum=20, no IDLE cycle, first sum=10 stable until ack.
- prod_valid=1 in IDLE -> drop_err=1 and remains 1 through a full accumulation; reset -> 0.
- Reset after 2 of 4 products -> IDLE, sum_valid=0, busy=0; new start plus 1,1,1,1 -> sum=4. With P_ACCUMULATOR_SAT_EN and ACC_WIDTH=16, two products of 65025 -> acc=65535, ovf=1 through HOLD.

Source files
------------

// File: rtl/p_accumulator_pkg.sv
// p_accum_pkg: shared types and helpers for the p_accumulator dot-product stage.
//   ST_*      : state encodings for the accumulator FSM
//   state_t   : FSM state enum (IDLE, ACCUM, HOLD)
//   acc_width : default accumulator width for a given operand width / vector length
//   cnt_width : product counter width, never narrower than one bit
package p_accum_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    HOLD  = ST_HOLD
  } state_t;

  // Width that can hold VEC_LEN full-scale products without overflow.
  function automatic int unsigned acc_width(input int unsigned width,
                                            input int unsigned vec_len);
    return 2 * width + $clog2(vec_len);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned vec_len);
    return (vec_len > 1) ? $clog2(vec_len) : 1;
  endfunction

endpackage

// File: rtl/p_accumulator_if.sv
// p_accumulator_if: product-in / sum-out bundle between the multiplier side
// (master) and the accumulator (slave).
//   start      : open a new accumulation
//   prod       : unsigned product, 2*WIDTH bits
//   prod_valid : prod is a new product this cycle
//   in_ready   : accumulator accepts products (feeds multiplier enable)
//   sum        : accumulated result, ACC_WIDTH bits
//   sum_valid  : sum valid and held stable
//   sum_ack    : consumer takes sum
//   busy       : accumulator not idle
//   drop_err   : sticky, a product arrived while in_ready was low
//   ovf        : sticky saturation flag (zero unless saturation is built in)
interface p_accumulator_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 20
);
  logic                   start;
  logic [2*WIDTH-1:0]     prod;
  logic                   prod_valid;
  logic                   in_ready;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   sum_valid;
  logic                   sum_ack;
  logic                   busy;
  logic                   drop_err;
  logic                   ovf;

  modport master (
    output start, prod, prod_valid, sum_ack,
    input  in_ready, sum, sum_valid, busy, drop_err, ovf
  );

  modport slave (
    input  start, prod, prod_valid, sum_ack,
    output in_ready, sum, sum_valid, busy, drop_err, ovf
  );
endinterface

// File: rtl/p_accumulator.sv
// p_accumulator: sums VEC_LEN unsigned products from p_multiplier into one
// dot-product result and holds it under a valid/ack handshake.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; dominates all inputs
//   bus   : p_accumulator_if.slave (start, prod, prod_valid, in_ready, sum,
//           sum_valid, sum_ack, busy, drop_err, ovf)
// Optional build macro P_ACCUMULATOR_SAT_EN: adds saturate at all ones and
// raise sticky ovf; otherwise adds wrap modulo 2^ACC_WIDTH and ovf stays 0.
module p_accumulator
  import p_accum_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned VEC_LEN   = 16,
  parameter int unsigned ACC_WIDTH = acc_width(WIDTH, VEC_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  p_accumulator_if.slave    bus
);

  localparam int unsigned        CNT_W    = cnt_width(VEC_LEN);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(VEC_LEN - 1);

  state_t               state, state_nx;
  logic [ACC_WIDTH-1:0] acc, acc_nx;
  logic [ACC_WIDTH-1:0] sum_q, sum_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 drop_q, drop_nx;
  logic                 ovf_q, ovf_nx;
  logic                 in_ready;

  logic [ACC_WIDTH-1:0] add_res;
  logic                 add_ovf;

`ifdef P_ACCUMULATOR_SAT_EN
  logic [ACC_WIDTH:0] add_wide;

  // One extra bit catches the carry; once acc is all ones any non-zero
  // product carries again, so saturation persists until the next start.
  always_comb begin
    add_wide = {1'b0, acc} + (ACC_WIDTH + 1)'(bus.prod);
    add_ovf  = add_wide[ACC_WIDTH];
    add_res  = add_ovf ? '1 : add_wide[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    add_res = acc + ACC_WIDTH'(bus.prod);
    add_ovf = 1'b0;
  end
`endif

  assign in_ready = (state == ACCUM);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    sum_nx   = sum_q;
    ovf_nx   = ovf_q;
    drop_nx  = drop_q | (bus.prod_valid & ~in_ready);

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = ACCUM;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end
      end

      ACCUM: begin
        if (bus.prod_valid) begin
          acc_nx = add_res;
          cnt_nx = cnt + CNT_W'(1);
          ovf_nx = ovf_q | add_ovf;
          if (cnt == CNT_LAST) begin
            sum_nx   = add_res;
            state_nx = HOLD;
          end
        end
      end

      HOLD: begin
        if (bus.sum_ack) begin
          if (bus.start) begin
            state_nx = ACCUM;
            acc_nx   = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      sum_q  <= '0;
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      sum_q  <= sum_nx;
      drop_q <= drop_nx;
      ovf_q  <= ovf_nx;
    end
  end

  // sum_valid is exactly "in HOLD": set on the accepting edge, cleared on ack.
  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state != IDLE);
  assign bus.sum_valid = (state == HOLD);
  assign bus.sum       = sum_q;
  assign bus.drop_err  = drop_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_p_accumulator.sv
module tb_p_accumulator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main DUT: WIDTH=8, VEC_LEN=4, default ACC_WIDTH = 16+2 = 18.
  p_accumulator_if #(.WIDTH(8), .ACC_WIDTH(18)) bus ();
  p_accumulator #(.WIDTH(8), .VEC_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow accumulator: wraps by default, saturates with P_ACCUMULATOR_SAT_EN.
  p_accumulator_if #(.WIDTH(8), .ACC_WIDTH(16)) bus2 ();
  p_accumulator #(.WIDTH(8), .VEC_LEN(4), .ACC_WIDTH(16)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // Single-product vector: ACC_WIDTH = 16+0 = 16.
  p_accumulator_if #(.WIDTH(8), .ACC_WIDTH(16)) bus3 ();
  p_accumulator #(.WIDTH(8), .VEC_LEN(1)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        st;
    logic [15:0] p;
    logic        pv;
    logic        ack;
    logic [17:0] e_sum;
    logic        e_sv;
    logic        e_rdy;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [15:0] p, input logic pv, input logic ack);
    bus.start = st; bus.prod = p; bus.prod_valid = pv; bus.sum_ack = ack;
  endtask

  task automatic row(input logic st, input logic [15:0] p, input logic pv, input logic ack,
                     input logic [17:0] es, input logic esv, input logic erdy, input logic ebusy);
    vec_t v;
    v.st = st; v.p = p; v.pv = pv; v.ack = ack;
    v.e_sum = es; v.e_sv = esv; v.e_rdy = erdy; v.e_busy = ebusy;
    tbl.push_back(v);
  endtask

  task automatic feed(input logic [15:0] p);
    drive(1'b0, p, 1'b1, 1'b0);
    step();
  endtask

  initial begin
    // Table: start, products 1..4, hold, ack, full-scale products, bubbles, back-to-back.
    row(1, 0,     0, 0, 0,      0, 1, 1);
    row(0, 1,     1, 0, 0,      0, 1, 1);
    row(0, 2,     1, 0, 0,      0, 1, 1);
    row(0, 3,     1, 0, 0,      0, 1, 1);
    row(0, 4,     1, 0, 10,     1, 0, 1);
    row(0, 0,     0, 0, 10,     1, 0, 1);
    row(1, 0,     0, 0, 10,     1, 0, 1);
    row(0, 0,     0, 0, 10,     1, 0, 1);
    row(1, 0,     0, 0, 10,     1, 0, 1);
    row(0, 0,     0, 0, 10,     1, 0, 1);
    row(0, 0,     0, 1, 10,     0, 0, 0);
    row(1, 0,     0, 0, 10,     0, 1, 1);
    row(0, 65025, 1, 0, 10,     0, 1, 1);
    row(0, 65025, 1, 0, 10,     0, 1, 1);
    row(0, 65025, 1, 0, 10,     0, 1, 1);
    row(0, 65025, 1, 0, 260100, 1, 0, 1);
    row(0, 0,     0, 1, 260100, 0, 0, 0);
    row(1, 0,     0, 0, 260100, 0, 1, 1);
    row(0, 999,   0, 0, 260100, 0, 1, 1);
    row(0, 1,     1, 0, 260100, 0, 1, 1);
    row(0, 999,   0, 0, 260100, 0, 1, 1);
    row(0, 2,     1, 0, 260100, 0, 1, 1);
    row(0, 999,   0, 0, 260100, 0, 1, 1);
    row(0, 3,     1, 0, 260100, 0, 1, 1);
    row(0, 999,   0, 0, 260100, 0, 1, 1);
    row(0, 999,   0, 0, 260100, 0, 1, 1);
    row(0, 4,     1, 0, 10,     1, 0, 1);
    row(0, 0,     0, 0, 10,     1, 0, 1);
    row(1, 0,     0, 1, 10,     0, 1, 1);
    row(0, 5,     1, 0, 10,     0, 1, 1);
    row(0, 5,     1, 0, 10,     0, 1, 1);
    row(0, 5,     1, 0, 10,     0, 1, 1);
    row(0, 5,     1, 0, 20,     1, 0, 1);
    row(0, 0,     0, 0, 20,     1, 0, 1);
    row(0, 0,     0, 1, 20,     0, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0);
    bus2.start = 0; bus2.prod = '0; bus2.prod_valid = 0; bus2.sum_ack = 0;
    bus3.start = 0; bus3.prod = '0; bus3.prod_valid = 0; bus3.sum_ack = 0;
    step();
    step();
    chk("rst_sum",   bus.sum,       0);
    chk("rst_sv",    bus.sum_valid, 0);
    chk("rst_rdy",   bus.in_ready,  0);
    chk("rst_busy",  bus.busy,      0);
    chk("rst_drop",  bus.drop_err,  0);
    chk("rst_ovf",   bus.ovf,       0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].p, tbl[i].pv, tbl[i].ack);
      step();
      chk($sformatf("row%0d_sum",  i), bus.sum,       tbl[i].e_sum);
      chk($sformatf("row%0d_sv",   i), bus.sum_valid, tbl[i].e_sv);
      chk($sformatf("row%0d_rdy",  i), bus.in_ready,  tbl[i].e_rdy);
      chk($sformatf("row%0d_busy", i), bus.busy,      tbl[i].e_busy);
      chk($sformatf("row%0d_drop", i), bus.drop_err,  0);
      chk($sformatf("row%0d_ovf",  i), bus.ovf,       0);
    end

    // Product while idle sets sticky drop_err; it survives a full accumulation.
    drive(0, 7, 1, 0);
    step();
    chk("drop_set",      bus.drop_err, 1);
    chk("drop_idle",     bus.busy,     0);
    chk("drop_sum_keep", bus.sum,      20);
    drive(1, 0, 0, 0);
    step();
    feed(1); feed(1); feed(1); feed(1);
    chk("drop_acc_sum",  bus.sum,       4);
    chk("drop_acc_sv",   bus.sum_valid, 1);
    chk("drop_sticky",   bus.drop_err,  1);
    drive(0, 0, 0, 1);
    step();
    chk("drop_after_ack", bus.drop_err, 1);
    drive(0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("drop_rst",      bus.drop_err, 0);
    chk("drop_rst_sum",  bus.sum,      0);

    // Reset after two of four products discards the partial sum.
    drive(1, 0, 0, 0);
    step();
    feed(1); feed(1);
    drive(0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_sv",   bus.sum_valid, 0);
    chk("midrst_busy", bus.busy,      0);
    chk("midrst_rdy",  bus.in_ready,  0);
    drive(1, 0, 0, 0);
    step();
    feed(1); feed(1); feed(1); feed(1);
    chk("midrst_sum",  bus.sum,       4);
    chk("midrst_sv2",  bus.sum_valid, 1);

    // Reset in HOLD together with start: reset wins.
    drive(1, 0, 0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    chk("rst_vs_start_busy", bus.busy,      0);
    chk("rst_vs_start_sv",   bus.sum_valid, 0);

    // Narrow accumulator: 65025 + 65025 overflows 16 bits.
    bus2.start = 1;
    step();
    bus2.start = 0;
    chk("n_busy", bus2.busy, 1);
    bus2.prod = 16'd65025; bus2.prod_valid = 1;
    step();
    step();
`ifdef P_ACCUMULATOR_SAT_EN
    chk("n_ovf_early", bus2.ovf, 1);
`else
    chk("n_ovf_early", bus2.ovf, 0);
`endif
    bus2.prod = 16'd0;
    step();
    step();
    bus2.prod_valid = 0;
    chk("n_sv", bus2.sum_valid, 1);
`ifdef P_ACCUMULATOR_SAT_EN
    chk("n_sum", bus2.sum, 65535);
    chk("n_ovf", bus2.ovf, 1);
`else
    chk("n_sum", bus2.sum, 64514);
    chk("n_ovf", bus2.ovf, 0);
`endif
    step();
`ifdef P_ACCUMULATOR_SAT_EN
    chk("n_ovf_hold", bus2.ovf, 1);
`else
    chk("n_ovf_hold", bus2.ovf, 0);
`endif
    bus2.sum_ack = 1; bus2.start = 1;
    step();
    bus2.sum_ack = 0; bus2.start = 0;
    chk("n_ovf_clr",  bus2.ovf,  0);
    chk("n_restart",  bus2.busy, 1);

    // VEC_LEN=1: first accepted product completes the accumulation.
    bus3.start = 1;
    step();
    bus3.start = 0;
    chk("v1_rdy", bus3.in_ready, 1);
    bus3.prod = 16'd300; bus3.prod_valid = 1;
    step();
    bus3.prod_valid = 0;
    chk("v1_sv",  bus3.sum_valid, 1);
    chk("v1_sum", bus3.sum,       300);
    chk("v1_rdy_hold", bus3.in_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
